// File: rtl/uart_rx_cfg.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_cfg
// Brief    : Parametrised UART receiver with configurable data width, parity
//            and stop bits, start-bit glitch rejection, error sideband flags
//            and a valid/ready holding register toward the consumer.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_cfg #(
    parameter int CLKS_PER_BIT = 143,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] c_CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] c_CNT_HALF  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] c_BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] c_STOP_LAST = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [1:0]           r_sync;
    logic                 r_rx_d;
    logic                 w_rx_s;
    logic [CW-1:0]        r_cnt;
    logic [CW-1:0]        w_cnt_nxt;
    logic [BW-1:0]        r_idx;
    logic [BW-1:0]        w_idx_nxt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic                 r_perr;
    logic                 w_perr_nxt;
    logic                 r_ferr;
    logic                 w_ferr_nxt;
    logic                 w_sample;
    logic                 w_done;

    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_perr_out;
    logic                 r_ferr_out;
    logic                 r_overrun;

    assign w_rx_s = r_sync[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= 2'b11;
            r_rx_d  <= 1'b1;
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], rx};
            r_rx_d  <= w_rx_s;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            r_perr  <= w_perr_nxt;
            r_ferr  <= w_ferr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CW'(1);
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_perr_nxt  = r_perr;
        w_ferr_nxt  = r_ferr;
        w_done      = 1'b0;
        w_sample    = (r_cnt == c_CNT_LAST);
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (r_rx_d && !w_rx_s) begin
                    w_state_nxt = S_START;
                    w_idx_nxt   = '0;
                    w_perr_nxt  = 1'b0;
                    w_ferr_nxt  = 1'b0;
                end
            end
            S_START: begin
                // A line that is high again at mid-bit was only a glitch.
                if (r_cnt == c_CNT_HALF) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_sample) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {w_rx_s, r_shift[DATA_BITS-1:1]};
                    if (r_idx == c_BIT_LAST) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        w_idx_nxt = r_idx + BW'(1);
                    end
                end
            end
            S_PARITY: begin
                if (w_sample) begin
                    w_cnt_nxt   = '0;
                    w_perr_nxt  = (((^r_shift) ^ w_rx_s) != (PARITY == 2));
                    w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (w_sample) begin
                    w_cnt_nxt  = '0;
                    w_ferr_nxt = r_ferr | ~w_rx_s;
                    if (r_idx == c_STOP_LAST) begin
                        w_idx_nxt   = '0;
                        w_done      = 1'b1;
                        w_state_nxt = (r_ferr | ~w_rx_s) ? S_BREAK : S_IDLE;
                    end else begin
                        w_idx_nxt = r_idx + BW'(1);
                    end
                end
            end
            S_BREAK: begin
                w_cnt_nxt = '0;
                if (w_rx_s) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Holding register: a completed frame loads only if the slot is free or
    // being drained in the same cycle; otherwise it is dropped as an overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_perr_out <= 1'b0;
            r_ferr_out <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_done) begin
                if (!r_valid || data_ready) begin
                    r_data     <= r_shift;
                    r_perr_out <= r_perr;
                    r_ferr_out <= w_ferr_nxt;
                    r_valid    <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && data_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign data       = r_data;
    assign data_valid = r_valid;
    assign parity_err = r_perr_out;
    assign frame_err  = r_ferr_out;
    assign overrun    = r_overrun;
    assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_cfg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_uart_rx_cfg
// Brief    : Scoreboard bench for uart_rx_cfg: an 8N1 instance and an 8E2
//            instance, each fed by a serial frame generator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_cfg;

    localparam int CPB_A = 143;
    localparam int CPB_B = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_a, rx_b, rdy_a, rdy_b;
    logic [7:0] data_a, data_b;
    logic       dv_a, pe_a, fe_a, ovr_a, busy_a;
    logic       dv_b, pe_b, fe_b, ovr_b, busy_b;

    int         n_cmp = 0;
    int         n_err = 0;
    int         vcnt_a = 0;
    int         ocnt_a = 0;
    int         bseen_a = 0;
    logic [9:0] q_a[$];
    logic [9:0] q_b[$];
    logic [9:0] e_a, e_b;

    always #5 clk = ~clk;

    uart_rx_cfg #(.CLKS_PER_BIT(CPB_A), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .rx(rx_a), .data(data_a), .data_valid(dv_a),
        .data_ready(rdy_a), .parity_err(pe_a), .frame_err(fe_a), .overrun(ovr_a), .busy(busy_a)
    );

    uart_rx_cfg #(.CLKS_PER_BIT(CPB_B), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .rx(rx_b), .data(data_b), .data_valid(dv_b),
        .data_ready(rdy_b), .parity_err(pe_b), .frame_err(fe_b), .overrun(ovr_b), .busy(busy_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic drive_bit(input bit which, input logic lvl, input int n);
        if (which) rx_b = lvl; else rx_a = lvl;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input bit which, input logic [7:0] d, input bit has_par,
                        input logic pbit, input int nstop, input logic [1:0] stop_lv);
        int cpb;
        cpb = which ? CPB_B : CPB_A;
        drive_bit(which, 1'b0, cpb);
        for (int i = 0; i < 8; i++) drive_bit(which, d[i], cpb);
        if (has_par) drive_bit(which, pbit, cpb);
        for (int i = 0; i < nstop; i++) drive_bit(which, stop_lv[i], cpb);
    endtask

    // Even parity: expected parity_err is set when the sent bit breaks even parity.
    task automatic exp_b(input logic [7:0] d, input logic pbit, input logic ferr);
        q_b.push_back({ferr, pbit ^ (^d), d});
    endtask

    task automatic exp_a(input logic [7:0] d, input logic ferr);
        q_a.push_back({ferr, 1'b0, d});
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (q_a.size() == 0 && q_b.size() == 0) break;
            @(negedge clk);
        end
        check_eq("drain", q_a.size() + q_b.size(), 0);
    endtask

    always @(negedge clk) begin
        if (dv_a) vcnt_a++;
        if (ovr_a) ocnt_a++;
        if (busy_a) bseen_a = 1;
        if (dv_a && rdy_a) begin
            if (q_a.size() == 0) begin
                check_eq("a_unexpected_valid", {31'b0, dv_a}, 0);
            end else begin
                e_a = q_a.pop_front();
                check_eq("a_data", {24'b0, data_a}, {24'b0, e_a[7:0]});
                check_eq("a_perr", {31'b0, pe_a}, {31'b0, e_a[8]});
                check_eq("a_ferr", {31'b0, fe_a}, {31'b0, e_a[9]});
            end
        end
        if (dv_b && rdy_b) begin
            if (q_b.size() == 0) begin
                check_eq("b_unexpected_valid", {31'b0, dv_b}, 0);
            end else begin
                e_b = q_b.pop_front();
                check_eq("b_data", {24'b0, data_b}, {24'b0, e_b[7:0]});
                check_eq("b_perr", {31'b0, pe_b}, {31'b0, e_b[8]});
                check_eq("b_ferr", {31'b0, fe_b}, {31'b0, e_b[9]});
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; rx_a = 1'b1; rx_b = 1'b1; rdy_a = 1'b1; rdy_b = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_outputs_a", {26'b0, data_a != 0, dv_a, pe_a, fe_a, ovr_a, busy_a}, 0);
        check_eq("rst_outputs_b", {26'b0, data_b != 0, dv_b, pe_b, fe_b, ovr_b, busy_b}, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // 8N1 words, consumer always ready
        vcnt_a = 0;
        exp_a(8'hA5, 1'b0);
        send(1'b0, 8'hA5, 1'b0, 1'b0, 1, 2'b11);
        repeat (5) @(negedge clk);
        check_eq("a_valid_one_cycle", vcnt_a, 1);
        exp_a(8'h00, 1'b0); send(1'b0, 8'h00, 1'b0, 1'b0, 1, 2'b11);
        exp_a(8'hFF, 1'b0); send(1'b0, 8'hFF, 1'b0, 1'b0, 1, 2'b11);
        wait_drain(2000);

        // start-bit glitch shorter than half a bit
        repeat (20) @(negedge clk);
        bseen_a = 0; vcnt_a = 0; ocnt_a = 0;
        drive_bit(1'b0, 1'b0, 60);
        drive_bit(1'b0, 1'b1, 200);
        check_eq("glitch_busy_seen", bseen_a, 1);
        check_eq("glitch_busy_end", {31'b0, busy_a}, 0);
        check_eq("glitch_no_valid", vcnt_a, 0);
        check_eq("glitch_no_overrun", ocnt_a, 0);

        // 8E2 instance: wrong parity, right parity, second stop bit low
        exp_b(8'h03, 1'b1, 1'b0); send(1'b1, 8'h03, 1'b1, 1'b1, 2, 2'b11);
        exp_b(8'h03, 1'b0, 1'b0); send(1'b1, 8'h03, 1'b1, 1'b0, 2, 2'b11);
        exp_b(8'h80, 1'b1, 1'b0); send(1'b1, 8'h80, 1'b1, 1'b1, 2, 2'b11);
        exp_b(8'h55, 1'b0, 1'b1); send(1'b1, 8'h55, 1'b1, 1'b0, 2, 2'b01);
        drive_bit(1'b1, 1'b1, 5 * CPB_B);
        exp_b(8'hC3, 1'b0, 1'b0); send(1'b1, 8'hC3, 1'b1, 1'b0, 2, 2'b11);
        drive_bit(1'b1, 1'b1, 2 * CPB_B);
        wait_drain(500);

        // stop bit held low for 5 bit times
        vcnt_a = 0;
        exp_a(8'h5A, 1'b1);
        send(1'b0, 8'h5A, 1'b0, 1'b0, 1, 2'b00);
        drive_bit(1'b0, 1'b0, 2 * CPB_A);
        check_eq("break_busy", {31'b0, busy_a}, 1);
        drive_bit(1'b0, 1'b0, 2 * CPB_A);
        check_eq("break_single_word", vcnt_a, 1);
        drive_bit(1'b0, 1'b1, 10);
        check_eq("break_released", {31'b0, busy_a}, 0);
        wait_drain(100);

        // consumer stalled: second word overruns
        rdy_a = 1'b0; ocnt_a = 0;
        exp_a(8'h11, 1'b0);
        send(1'b0, 8'h11, 1'b0, 1'b0, 1, 2'b11);
        send(1'b0, 8'h22, 1'b0, 1'b0, 1, 2'b11);
        drive_bit(1'b0, 1'b1, 20);
        check_eq("ovr_pulse_count", ocnt_a, 1);
        check_eq("ovr_valid_held", {31'b0, dv_a}, 1);
        check_eq("ovr_data_held", {24'b0, data_a}, 32'h11);
        rdy_a = 1'b1;
        wait_drain(100);
        @(negedge clk);
        check_eq("valid_clear", {31'b0, dv_a}, 0);

        // reset in the middle of a frame
        rdy_a = 1'b0;
        send(1'b0, 8'h3C, 1'b0, 1'b0, 1, 2'b11);
        drive_bit(1'b0, 1'b1, 10);
        check_eq("pre_rst_valid", {31'b0, dv_a}, 1);
        drive_bit(1'b0, 1'b0, CPB_A);
        for (int i = 0; i < 4; i++) drive_bit(1'b0, (8'h7E >> i) & 1'b1, CPB_A);
        #2 rst_n = 1'b0;
        #1;
        check_eq("midrst_outputs", {26'b0, data_a != 0, dv_a, pe_a, fe_a, ovr_a, busy_a}, 0);
        rx_a = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1; rdy_a = 1'b1;
        repeat (3) @(negedge clk);
        exp_a(8'h81, 1'b0);
        send(1'b0, 8'h81, 1'b0, 1'b0, 1, 2'b11);
        drive_bit(1'b0, 1'b1, 10);
        wait_drain(100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
